// File: rtl/conv_pkg.sv
// Shared types and width helpers for the conv/upsample pipeline blocks.
package conv_pkg;

  typedef enum logic {PASS, REPLAY} upsample_state_e;

  // Counter width for values 0..value-1; never narrower than one bit.
  function automatic int widthOf(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/line_ram.sv
// Single-row line buffer: synchronous write, asynchronous (distributed) read.
module line_ram
  import conv_pkg::*;
#(
  parameter int Depth = 160,
  parameter int Width = 1,
  localparam int AddrWidth = widthOf(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/upsample_layer.sv
// Nearest-neighbour upsampler: each pixel repeated Scale times, each row replayed Scale times.
// Define UPSAMPLE_ZERO_INSERT_EN for transposed-conv zero insertion instead of replication.
module upsample_layer
  import conv_pkg::*;
#(
  parameter int LineWidthPx = 160,
  parameter int LineCountPx = 120,
  parameter int Width       = 1,
  parameter int Scale       = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  localparam int XWidth     = widthOf(LineWidthPx);
  localparam int YWidth     = widthOf(LineCountPx);
  localparam int ScaleWidth = widthOf(Scale);

  localparam logic [XWidth-1:0]     XLast = XWidth'(LineWidthPx - 1);
  localparam logic [YWidth-1:0]     YLast = YWidth'(LineCountPx - 1);
  localparam logic [ScaleWidth-1:0] SLast = ScaleWidth'(Scale - 1);

  if (Scale < 1) begin : g_scaleCheck
    $error("upsample_layer: Scale must be >= 1");
  end

  upsample_state_e       r_state;
  logic                  r_valid;
  logic [Width-1:0]      r_data;
  logic [ScaleWidth-1:0] r_hCnt;
  logic [ScaleWidth-1:0] r_vCnt;
  logic [XWidth-1:0]     r_xPos;
  logic [YWidth-1:0]     r_yPos;

  logic             w_loadEn;
  logic             w_hLast;
  logic             w_xLast;
  logic             w_vLast;
  logic             w_yLast;
  logic             w_inFire;
  logic [Width-1:0] w_passData;
  logic [Width-1:0] w_replayData;

  assign w_loadEn = ~r_valid | ready_i;
  assign w_hLast  = (r_hCnt == SLast);
  assign w_xLast  = (r_xPos == XLast);
  assign w_vLast  = (r_vCnt == SLast);
  assign w_yLast  = (r_yPos == YLast);
  assign ready_o  = (r_state == PASS) & w_loadEn & w_hLast;
  assign w_inFire = valid_i & ready_o;

`ifdef UPSAMPLE_ZERO_INSERT_EN
  assign w_passData   = (r_hCnt == '0) ? data_i : '0;
  assign w_replayData = '0;
`else
  logic [Width-1:0] w_ramData;

  line_ram #(
    .Depth (LineWidthPx),
    .Width (Width)
  ) u_lineRam (
    .clk_i   (clk_i),
    .we_i    (w_inFire),
    .waddr_i (r_xPos),
    .wdata_i (data_i),
    .raddr_i (r_xPos),
    .rdata_o (w_ramData)
  );

  assign w_passData   = data_i;
  assign w_replayData = w_ramData;
`endif

  // The last horizontal copy in PASS is exactly the in_fire cycle, so the pixel is consumed there.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= PASS;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_hCnt  <= '0;
      r_vCnt  <= '0;
      r_xPos  <= '0;
      r_yPos  <= '0;
    end else if (w_loadEn) begin
      case (r_state)
        PASS: begin
          if (valid_i) begin
            r_valid <= 1'b1;
            r_data  <= w_passData;
            if (w_hLast) begin
              r_hCnt <= '0;
              if (w_xLast) begin
                r_xPos <= '0;
                if (Scale == 1) begin
                  r_yPos <= w_yLast ? '0 : r_yPos + 1'b1;
                end else begin
                  r_state <= REPLAY;
                  r_vCnt  <= ScaleWidth'(1);
                end
              end else begin
                r_xPos <= r_xPos + 1'b1;
              end
            end else begin
              r_hCnt <= r_hCnt + 1'b1;
            end
          end else begin
            r_valid <= 1'b0;
          end
        end
        REPLAY: begin
          r_valid <= 1'b1;
          r_data  <= w_replayData;
          if (w_hLast) begin
            r_hCnt <= '0;
            if (w_xLast) begin
              r_xPos <= '0;
              if (w_vLast) begin
                r_state <= PASS;
                r_vCnt  <= '0;
                r_yPos  <= w_yLast ? '0 : r_yPos + 1'b1;
              end else begin
                r_vCnt <= r_vCnt + 1'b1;
              end
            end else begin
              r_xPos <= r_xPos + 1'b1;
            end
          end else begin
            r_hCnt <= r_hCnt + 1'b1;
          end
        end
        default: r_state <= PASS;
      endcase
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;

endmodule

// File: tb/tb_upsample_layer.sv
// Directed self-checking bench for upsample_layer; four instances cover Scale 1/2/3 and a 2x2 frame.
module tb_upsample_layer;

  logic       clk;
  logic       rst    [4];
  logic       vin    [4];
  logic       rdyIn  [4];
  logic [7:0] din    [4];
  logic       rdyOut [4];
  logic       vout   [4];
  logic [7:0] dout   [4];

  int passCount;
  int checkCount;
  int stableErr;
  int inFires;
  int firstOutCycle;
  int lastOutCycle;

  logic [7:0] inPix [$];
  logic [7:0] outQ  [$];
  logic [7:0] expQ  [$];

  upsample_layer #(.LineWidthPx(4), .LineCountPx(2), .Width(8), .Scale(2)) dutS2 (
    .clk_i(clk), .rst_i(rst[0]), .valid_i(vin[0]), .ready_o(rdyOut[0]), .data_i(din[0]),
    .valid_o(vout[0]), .ready_i(rdyIn[0]), .data_o(dout[0]));

  upsample_layer #(.LineWidthPx(4), .LineCountPx(2), .Width(8), .Scale(1)) dutS1 (
    .clk_i(clk), .rst_i(rst[1]), .valid_i(vin[1]), .ready_o(rdyOut[1]), .data_i(din[1]),
    .valid_o(vout[1]), .ready_i(rdyIn[1]), .data_o(dout[1]));

  upsample_layer #(.LineWidthPx(2), .LineCountPx(2), .Width(8), .Scale(2)) dutSmall (
    .clk_i(clk), .rst_i(rst[2]), .valid_i(vin[2]), .ready_o(rdyOut[2]), .data_i(din[2]),
    .valid_o(vout[2]), .ready_i(rdyIn[2]), .data_o(dout[2]));

  upsample_layer #(.LineWidthPx(4), .LineCountPx(2), .Width(8), .Scale(3)) dutS3 (
    .clk_i(clk), .rst_i(rst[3]), .valid_i(vin[3]), .ready_o(rdyOut[3]), .data_i(din[3]),
    .valid_o(vout[3]), .ready_i(rdyIn[3]), .data_o(dout[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference output stream built directly from the raster definition, independent of RTL counters.
  task automatic buildExpected(input int w, input int h, input int s, input int frames);
    logic [7:0] p;
    expQ.delete();
    for (int f = 0; f < frames; f++)
      for (int r = 0; r < h; r++)
        for (int v = 0; v < s; v++)
          for (int c = 0; c < w; c++)
            for (int hh = 0; hh < s; hh++) begin
              p = inPix[f*w*h + r*w + c];
`ifdef UPSAMPLE_ZERO_INSERT_EN
              if (v != 0 || hh != 0) p = 8'h00;
`endif
              expQ.push_back(p);
            end
  endtask

  task automatic resetDut(input int sel);
    @(negedge clk);
    rst[sel] = 1'b1; vin[sel] = 1'b0; rdyIn[sel] = 1'b1; din[sel] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst[sel] = 1'b0;
  endtask

  // Streams inPix into one instance and collects every out_fire; stops at nOut or abortAfter outputs.
  task automatic applyStimulus(input int sel, input int nOut, input bit randReady,
                               input int abortAfter, output bit timedOut);
    int idx;
    int cycles;
    bit pendHold;
    logic [7:0] holdData;
    idx = 0; cycles = 0; pendHold = 1'b0; holdData = 8'h00; timedOut = 1'b0;
    outQ.delete(); inFires = 0; stableErr = 0; firstOutCycle = -1; lastOutCycle = -1;
    while (outQ.size() < nOut && !(abortAfter >= 0 && outQ.size() >= abortAfter)) begin
      @(negedge clk);
      if (pendHold && (vout[sel] !== 1'b1 || dout[sel] !== holdData)) stableErr++;
      vin[sel]   = (idx < inPix.size());
      din[sel]   = (idx < inPix.size()) ? inPix[idx] : 8'h00;
      rdyIn[sel] = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (vin[sel] && rdyOut[sel]) begin
        idx++;
        inFires++;
      end
      if (vout[sel] && rdyIn[sel]) begin
        outQ.push_back(dout[sel]);
        if (firstOutCycle < 0) firstOutCycle = cycles;
        lastOutCycle = cycles;
      end
      pendHold = vout[sel] && !rdyIn[sel];
      holdData = dout[sel];
      cycles++;
      if (cycles > 5000) begin
        timedOut = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    vin[sel] = 1'b0;
    rdyIn[sel] = 1'b1;
  endtask

  task automatic compareStream(input string name);
    checkCount++;
    if (outQ.size() !== expQ.size())
      $display("[TB] FAIL %s count: got %0d outputs, expected %0d", name, outQ.size(), expQ.size());
    else passCount++;
    for (int i = 0; i < expQ.size() && i < outQ.size(); i++) begin
      checkCount++;
      if (outQ[i] !== expQ[i])
        $display("[TB] FAIL %s pixel %0d: got %0d expected %0d", name, i, outQ[i], expQ[i]);
      else passCount++;
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 4; s++) resetDut(s);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      checkCount++;
      if (vout[s] !== 1'b0 || dout[s] !== 8'h00 || rdyOut[s] !== (s == 1 ? 1'b1 : 1'b0))
        $display("[TB] FAIL reset dut%0d: got v=%b d=%0d r=%b expected v=0 d=0 r=%b",
                 s, vout[s], dout[s], rdyOut[s], (s == 1));
      else passCount++;
    end
  endtask

  task automatic test_replicate();
    bit to;
    inPix.delete();
    for (int i = 1; i <= 8; i++) inPix.push_back(8'(i));
    buildExpected(4, 2, 2, 1);
    resetDut(0);
    applyStimulus(0, 32, 1'b0, -1, to);
    checkCount++;
    if (to !== 1'b0) $display("[TB] FAIL replicate timeout: got %b expected 0", to); else passCount++;
    compareStream("replicate");
    checkCount++;
    if (inFires !== 8) $display("[TB] FAIL replicate inFires: got %0d expected 8", inFires); else passCount++;
    checkCount++;
    if (firstOutCycle !== 1) $display("[TB] FAIL replicate latency: got %0d expected 1", firstOutCycle); else passCount++;
    checkCount++;
    if (lastOutCycle - firstOutCycle + 1 !== 32)
      $display("[TB] FAIL replicate span: got %0d expected 32", lastOutCycle - firstOutCycle + 1);
    else passCount++;
  endtask

  task automatic test_backpressure();
    bit to;
    buildExpected(4, 2, 2, 1);
    resetDut(0);
    applyStimulus(0, 32, 1'b1, -1, to);
    checkCount++;
    if (to !== 1'b0) $display("[TB] FAIL backpressure timeout: got %b expected 0", to); else passCount++;
    compareStream("backpressure");
    checkCount++;
    if (stableErr !== 0) $display("[TB] FAIL backpressure hold: got %0d changes expected 0", stableErr); else passCount++;
  endtask

  task automatic test_passthrough();
    resetDut(1);
    @(negedge clk);
    vin[1] = 1'b1; din[1] = 8'd9; rdyIn[1] = 1'b1;
    #1;
    checkCount++;
    if (rdyOut[1] !== 1'b1) $display("[TB] FAIL pass ready0: got %b expected 1", rdyOut[1]); else passCount++;
    @(negedge clk);
    checkCount++;
    if (vout[1] !== 1'b1 || dout[1] !== 8'd9) $display("[TB] FAIL pass out9: got v=%b d=%0d expected v=1 d=9", vout[1], dout[1]); else passCount++;
    din[1] = 8'd10;
    @(negedge clk);
    checkCount++;
    if (vout[1] !== 1'b1 || dout[1] !== 8'd10) $display("[TB] FAIL pass out10: got v=%b d=%0d expected v=1 d=10", vout[1], dout[1]); else passCount++;
    din[1] = 8'd11; rdyIn[1] = 1'b0;
    #1;
    checkCount++;
    if (rdyOut[1] !== 1'b0) $display("[TB] FAIL pass stallReady: got %b expected 0", rdyOut[1]); else passCount++;
    @(negedge clk);
    checkCount++;
    if (vout[1] !== 1'b1 || dout[1] !== 8'd10) $display("[TB] FAIL pass hold: got v=%b d=%0d expected v=1 d=10", vout[1], dout[1]); else passCount++;
    rdyIn[1] = 1'b1;
    #1;
    checkCount++;
    if (rdyOut[1] !== 1'b1) $display("[TB] FAIL pass resumeReady: got %b expected 1", rdyOut[1]); else passCount++;
    @(negedge clk);
    checkCount++;
    if (vout[1] !== 1'b1 || dout[1] !== 8'd11) $display("[TB] FAIL pass out11: got v=%b d=%0d expected v=1 d=11", vout[1], dout[1]); else passCount++;
    vin[1] = 1'b0;
    @(negedge clk);
    checkCount++;
    if (vout[1] !== 1'b0) $display("[TB] FAIL pass drain: got v=%b expected 0", vout[1]); else passCount++;
  endtask

  task automatic test_reset_mid_replay();
    bit to;
    buildExpected(4, 2, 2, 1);
    resetDut(0);
    applyStimulus(0, 32, 1'b0, 10, to);
    @(negedge clk);
    checkCount++;
    if (vout[0] !== 1'b1) $display("[TB] FAIL midReplay active: got v=%b expected 1", vout[0]); else passCount++;
    rst[0] = 1'b1;
    @(negedge clk);
    checkCount++;
    if (vout[0] !== 1'b0 || dout[0] !== 8'h00) $display("[TB] FAIL midReplay reset: got v=%b d=%0d expected v=0 d=0", vout[0], dout[0]); else passCount++;
    rst[0] = 1'b0;
    applyStimulus(0, 32, 1'b0, -1, to);
    compareStream("afterReset");
  endtask

  task automatic test_small_frame();
    bit to;
    inPix.delete();
    for (int i = 1; i <= 4; i++) inPix.push_back(8'(i));
    buildExpected(2, 2, 2, 1);
    resetDut(2);
    applyStimulus(2, 16, 1'b0, -1, to);
    checkCount++;
    if (to !== 1'b0) $display("[TB] FAIL small timeout: got %b expected 0", to); else passCount++;
    compareStream("small");
  endtask

  task automatic test_back_to_back();
    bit to;
    inPix.delete();
    for (int i = 1; i <= 8; i++) inPix.push_back(8'(i));
    for (int i = 11; i <= 18; i++) inPix.push_back(8'(i));
    buildExpected(4, 2, 3, 2);
    resetDut(3);
    applyStimulus(3, 144, 1'b0, -1, to);
    checkCount++;
    if (to !== 1'b0) $display("[TB] FAIL b2b timeout: got %b expected 0", to); else passCount++;
    compareStream("b2b");
    checkCount++;
    if (inFires !== 16) $display("[TB] FAIL b2b inFires: got %0d expected 16", inFires); else passCount++;
  endtask

  initial begin
    passCount = 0;
    checkCount = 0;
    for (int s = 0; s < 4; s++) begin
      rst[s] = 1'b1; vin[s] = 1'b0; rdyIn[s] = 1'b1; din[s] = 8'h00;
    end
    test_reset();
    test_replicate();
    test_backpressure();
    test_passthrough();
    test_reset_mid_replay();
    test_small_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
